// File: rtl/coin_payer.sv
// Buyer-side coin feeder for the single-drink vending seller: pays 1.5 yuan
// from a small wallet, then checks the seller's drink and change response.
module coin_payer #(
  parameter int TIMEOUT = 4,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] ld_n1,
  input  logic [CW-1:0] ld_n2,
  input  logic [CW-1:0] ld_n3,
  input  logic          start,
  input  logic          drink,
  input  logic [1:0]    change,
  output logic          d1,
  output logic          d2,
  output logic          d3,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [1:0]    chg_q
);

  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_NOFUNDS = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_BADCHG  = 2'd3;

  typedef enum logic [1:0] {IDLE, PAY, WAIT} state_t;

  state_t        state;
  logic [2:0]    paid;
  logic [WW-1:0] wait_cnt;

  logic [CW+2:0] wallet;
  logic          funds_ok;
  logic [2:0]    pay_base;
  logic [2:0]    need;
  logic [1:0]    pick;
  logic [2:0]    coin_val;
  logic [2:0]    paid_nxt;
  logic          issue;

  assign wallet   = {3'b000, cnt1} + {2'b00, cnt2, 1'b0} + {1'b0, cnt3, 2'b00};
  assign funds_ok = wallet >= (CW+3)'(3);

  // The first coin goes out on the start edge itself, so IDLE pays from zero.
  assign pay_base = (state == PAY) ? paid : 3'd0;
  assign need     = 3'd3 - pay_base;
  assign issue    = (state == PAY) ||
                    ((state == IDLE) && !load && start && funds_ok);

  // Largest coin not exceeding the shortfall, otherwise the smallest one left.
  always_comb begin
    pick = 2'd0;
    if (need >= 3'd2 && cnt2 != '0)
      pick = 2'd2;
    else if (cnt1 != '0)
      pick = 2'd1;
    else if (cnt2 != '0)
      pick = 2'd2;
    else if (cnt3 != '0)
      pick = 2'd3;
  end

  always_comb begin
    coin_val = 3'd0;
    case (pick)
      2'd1:    coin_val = 3'd1;
      2'd2:    coin_val = 3'd2;
      2'd3:    coin_val = 3'd4;
      default: coin_val = 3'd0;
    endcase
  end

  assign paid_nxt = pay_base + coin_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      paid     <= '0;
      wait_cnt <= '0;
      d1       <= 1'b0;
      d2       <= 1'b0;
      d3       <= 1'b0;
      cnt1     <= '0;
      cnt2     <= '0;
      cnt3     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      status   <= '0;
      chg_q    <= '0;
    end else begin
      d1   <= 1'b0;
      d2   <= 1'b0;
      d3   <= 1'b0;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            cnt1 <= ld_n1;
            cnt2 <= ld_n2;
            cnt3 <= ld_n3;
          end else if (start && !funds_ok) begin
            done   <= 1'b1;
            status <= ST_NOFUNDS;
          end
        end
        WAIT: begin
          if (drink) begin
            chg_q  <= change;
            done   <= 1'b1;
            status <= ({1'b0, change} == (paid - 3'd3)) ? ST_OK : ST_BADCHG;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            done   <= 1'b1;
            status <= ST_TIMEOUT;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: ;
      endcase

      if (issue) begin
        case (pick)
          2'd1: begin d1 <= 1'b1; cnt1 <= cnt1 - CW'(1); end
          2'd2: begin d2 <= 1'b1; cnt2 <= cnt2 - CW'(1); end
          2'd3: begin d3 <= 1'b1; cnt3 <= cnt3 - CW'(1); end
          default: ;
        endcase
        paid <= paid_nxt;
        busy <= 1'b1;
        if (paid_nxt >= 3'd3) begin
          state    <= WAIT;
          wait_cnt <= '0;
        end else begin
          state <= PAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_coin_payer.sv
// Directed bench for coin_payer against a small behavioural seller that
// answers two cycles after the paying coin, with mute and forced-change knobs.
module tb_coin_payer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load, start;
  logic [CW-1:0] ld_n1, ld_n2, ld_n3;
  logic          drink;
  logic [1:0]    change;
  logic          d1, d2, d3;
  logic [CW-1:0] cnt1, cnt2, cnt3;
  logic          busy, done;
  logic [1:0]    status, chg_q;

  int n_cmp = 0;
  int n_err = 0;

  logic       mute = 1'b0;
  logic       force_chg = 1'b0;
  logic [2:0] acc;
  logic       s1;
  logic [1:0] s1_chg;

  always #5 clk = ~clk;

  coin_payer #(.TIMEOUT(4), .CW(CW)) dut (
    .clk(clk), .rst(rst), .load(load),
    .ld_n1(ld_n1), .ld_n2(ld_n2), .ld_n3(ld_n3),
    .start(start), .drink(drink), .change(change),
    .d1(d1), .d2(d2), .d3(d3),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .busy(busy), .done(done), .status(status), .chg_q(chg_q)
  );

  // Seller: coin in cycle c completes the price -> drink high in cycle c+2.
  always @(posedge clk) begin
    logic [2:0] v;
    logic [2:0] sum;
    if (!rst) begin
      acc <= '0; s1 <= 1'b0; s1_chg <= '0; drink <= 1'b0; change <= '0;
    end else begin
      v   = d1 ? 3'd1 : d2 ? 3'd2 : d3 ? 3'd4 : 3'd0;
      sum = acc + v;
      if (sum >= 3'd3) begin
        s1     <= 1'b1;
        s1_chg <= 2'(sum - 3'd3);
        acc    <= '0;
      end else begin
        s1  <= 1'b0;
        acc <= sum;
      end
      drink  <= s1 && !mute;
      change <= (s1 && !mute && !force_chg) ? s1_chg : 2'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_wallet(input logic [CW-1:0] a, input logic [CW-1:0] b,
                             input logic [CW-1:0] c);
    ld_n1 = a; ld_n2 = b; ld_n3 = c; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Raises start for one edge and records coin codes {d3,d2,d1} and busy
  // for every cycle up to and including the done cycle (bounded).
  task automatic run_txn(output logic [29:0] seq, output logic [9:0] bseq,
                         output int ncyc);
    seq = '0; bseq = '0; ncyc = 0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      seq  = {seq[26:0], d3, d2, d1};
      bseq = {bseq[8:0], busy};
      ncyc++;
      if (done) break;
    end
  endtask

  logic [29:0] seq;
  logic [9:0]  bseq;
  int          ncyc;
  logic        any_act;

  initial begin
    rst = 1'b0; load = 1'b0; start = 1'b0;
    ld_n1 = '0; ld_n2 = '0; ld_n3 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {d3, d2, d1, busy, done, status, chg_q, cnt1, cnt2, cnt3}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // (3,0,0): three half-yuan coins back to back
    load_wallet(4'd3, 4'd0, 4'd0);
    chk("load_visible", {cnt1, cnt2, cnt3}, 32'h300);
    run_txn(seq, bseq, ncyc);
    chk("t1_seq", seq, 30'o111000);
    chk("t1_cycles", ncyc, 6);
    chk("t1_busy", bseq, 10'b111110);
    chk("t1_status", status, 2'd0);
    chk("t1_chg", chg_q, 2'd0);
    chk("t1_cnts", {cnt1, cnt2, cnt3}, 32'h000);

    // (0,0,1): single 2-yuan coin, 0.5 change
    load_wallet(4'd0, 4'd0, 4'd1);
    run_txn(seq, bseq, ncyc);
    chk("t2_seq", seq, 30'o4000);
    chk("t2_cycles", ncyc, 4);
    chk("t2_busy", bseq, 10'b1110);
    chk("t2_status", status, 2'd0);
    chk("t2_chg", chg_q, 2'd1);
    chk("t2_cnts", {cnt1, cnt2, cnt3}, 32'h000);

    // (1,1,1): d2 then d1, 2-yuan coin kept
    load_wallet(4'd1, 4'd1, 4'd1);
    run_txn(seq, bseq, ncyc);
    chk("t3_seq", seq, 30'o21000);
    chk("t3_cycles", ncyc, 5);
    chk("t3_status", status, 2'd0);
    chk("t3_cnts", {cnt1, cnt2, cnt3}, 32'h001);

    // (0,2,0): overpay with a second 1-yuan coin
    load_wallet(4'd0, 4'd2, 4'd0);
    run_txn(seq, bseq, ncyc);
    chk("t4_seq", seq, 30'o22000);
    chk("t4_status", status, 2'd0);
    chk("t4_chg", chg_q, 2'd1);

    // (2,0,0): insufficient funds
    load_wallet(4'd2, 4'd0, 4'd0);
    run_txn(seq, bseq, ncyc);
    chk("t5_seq", seq, 30'o0);
    chk("t5_cycles", ncyc, 1);
    chk("t5_busy", bseq, 10'b0);
    chk("t5_status", status, 2'd1);
    chk("t5_cnts", {cnt1, cnt2, cnt3}, 32'h200);

    // load and start together: load wins
    ld_n1 = 4'd0; ld_n2 = 4'd0; ld_n3 = 4'd1; load = 1'b1; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("ldst_cnts", {cnt1, cnt2, cnt3}, 32'h001);
    chk("ldst_idle", {busy, d3, done}, 3'b000);

    // muted seller: timeout after TIMEOUT wait cycles, chg_q untouched
    mute = 1'b1;
    run_txn(seq, bseq, ncyc);
    chk("t6_seq", seq, 30'o40000);
    chk("t6_cycles", ncyc, 5);
    chk("t6_busy", bseq, 10'b11110);
    chk("t6_status", status, 2'd2);
    chk("t6_chg", chg_q, 2'd1);
    chk("t6_cnts", {cnt1, cnt2, cnt3}, 32'h000);
    @(negedge clk);
    chk("t6_held", {done, status}, 3'b010);
    mute = 1'b0;

    // forced wrong change: status 3
    force_chg = 1'b1;
    load_wallet(4'd0, 4'd2, 4'd0);
    run_txn(seq, bseq, ncyc);
    chk("t7_seq", seq, 30'o22000);
    chk("t7_status", status, 2'd3);
    chk("t7_chg", chg_q, 2'd0);
    force_chg = 1'b0;

    // reset mid-run after the first coin
    load_wallet(4'd3, 4'd0, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t8_first", {d3, d2, d1, busy}, 4'b0011);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t8_cleared", {d3, d2, d1, busy, done, status, chg_q, cnt1, cnt2, cnt3}, 32'h0);
    any_act = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_act = any_act | d1 | d2 | d3 | done | busy;
    end
    chk("t8_quiet", any_act, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
